// File: rtl/word_slice_serializer_if.sv
// Word-in / slice-out handshake bundle for word_slice_serializer.
// The master side is the word producer plus slice consumer; the slave side is the serializer.
interface word_slice_serializer_if #(
    parameter int WORD_W  = 16,
    parameter int SLICE_W = 8
);
    localparam int NSLICE = WORD_W / SLICE_W;
    localparam int IDX_W  = (NSLICE > 2) ? $clog2(NSLICE) : 1;

    logic               in_valid;
    logic               in_ready;
    logic [WORD_W-1:0]  in_word;
    logic [1:0]         in_mode;
    logic               out_valid;
    logic               out_ready;
    logic [SLICE_W-1:0] out_slice;
    logic [IDX_W-1:0]   out_idx;
    logic               out_last;

    modport master (
        output in_valid, in_word, in_mode, out_ready,
        input  in_ready, out_valid, out_slice, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_word, in_mode, out_ready,
        output in_ready, out_valid, out_slice, out_idx, out_last
    );
endinterface

// File: rtl/word_slice_serializer.sv
// Splits WORD_W-bit words into SLICE_W-bit slices in a per-word order
// (MSB-first, LSB-first, legacy single-slice select, MSB-first skipping zero slices).
module word_slice_serializer #(
    parameter int WORD_W  = 16,
    parameter int SLICE_W = 8
) (
    input logic                    clk,
    input logic                    rst,
    word_slice_serializer_if.slave bus
);
    localparam int NSLICE = WORD_W / SLICE_W;
    localparam int IDX_W  = (NSLICE > 2) ? $clog2(NSLICE) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    localparam logic [1:0] MODE_MSB   = 2'd0;
    localparam logic [1:0] MODE_LSB   = 2'd1;
    localparam logic [1:0] MODE_SEL   = 2'd2;
    localparam logic [1:0] MODE_SKIPZ = 2'd3;

    logic [0:0]         state_r;
    logic [WORD_W-1:0]  wordHeld_r;
    logic [1:0]         modeHeld_r;
    logic [NSLICE-1:0]  maskHeld_r;
    logic [SLICE_W-1:0] outSlice_r;
    logic [IDX_W-1:0]   outIdx_r;
    logic               outLast_r;

    logic [NSLICE-1:0]  inMask_s;
    logic [IDX_W:0]     inHi_s;
    logic [IDX_W:0]     inLo_s;
    logic [IDX_W-1:0]   firstIdx_s;
    logic               firstLast_s;
    logic [IDX_W:0]     heldHi_s;
    logic [IDX_W:0]     heldLo_s;
    logic [IDX_W-1:0]   nextIdx_s;
    logic               nextLast_s;
    logic               inReady_s;
    logic               acceptWord_s;
    logic               advance_s;
    logic               finish_s;

    function automatic logic [SLICE_W-1:0] sliceOf(input logic [WORD_W-1:0] w,
                                                   input logic [IDX_W-1:0]  k);
        logic [SLICE_W-1:0] res;
        res = {SLICE_W{1'b0}};
        for (int i = 0; i < NSLICE; i++) begin
            res = (k == IDX_W'(i)) ? w[i*SLICE_W +: SLICE_W] : res;
        end
        return res;
    endfunction

    function automatic logic [NSLICE-1:0] nzMask(input logic [WORD_W-1:0] w);
        logic [NSLICE-1:0] res;
        res = {NSLICE{1'b0}};
        for (int i = 0; i < NSLICE; i++) begin
            res[i] = |w[i*SLICE_W +: SLICE_W];
        end
        return res;
    endfunction

    // Returns {found, index} of the highest set mask bit strictly below lim.
    function automatic logic [IDX_W:0] highestBelow(input logic [NSLICE-1:0] mask,
                                                    input int               lim);
        logic [IDX_W:0] res;
        res = {(IDX_W+1){1'b0}};
        for (int i = 0; i < NSLICE; i++) begin
            res = ((i < lim) && mask[i]) ? {1'b1, IDX_W'(i)} : res;
        end
        return res;
    endfunction

    // First beat of the word currently offered on the input side.
    always_comb begin
        inMask_s    = nzMask(bus.in_word);
        inHi_s      = highestBelow(inMask_s, NSLICE);
        inLo_s      = highestBelow(inMask_s, int'(inHi_s[IDX_W-1:0]));
        firstIdx_s  = IDX_W'(NSLICE-1);
        firstLast_s = 1'b0;
        case (bus.in_mode)
            MODE_MSB: begin
                firstIdx_s  = IDX_W'(NSLICE-1);
                firstLast_s = 1'b0;
            end
            MODE_LSB: begin
                firstIdx_s  = {IDX_W{1'b0}};
                firstLast_s = 1'b0;
            end
            MODE_SEL: begin
                firstIdx_s  = (bus.in_word[WORD_W-1] & bus.in_word[SLICE_W]) ?
                              {IDX_W{1'b0}} : IDX_W'(NSLICE-1);
                firstLast_s = 1'b1;
            end
            MODE_SKIPZ: begin
                // An all-zero word leaves inHi_s clear, so this yields slice 0 as the last beat.
                firstIdx_s  = inHi_s[IDX_W-1:0];
                firstLast_s = ~inLo_s[IDX_W];
            end
            default: begin
                firstIdx_s  = IDX_W'(NSLICE-1);
                firstLast_s = 1'b0;
            end
        endcase
    end

    // Following beat of the word being emitted.
    always_comb begin
        heldHi_s   = highestBelow(maskHeld_r, int'(outIdx_r));
        heldLo_s   = highestBelow(maskHeld_r, int'(heldHi_s[IDX_W-1:0]));
        nextIdx_s  = outIdx_r;
        nextLast_s = 1'b1;
        case (modeHeld_r)
            MODE_MSB: begin
                nextIdx_s  = outIdx_r - IDX_W'(1);
                nextLast_s = (outIdx_r == IDX_W'(1));
            end
            MODE_LSB: begin
                nextIdx_s  = outIdx_r + IDX_W'(1);
                nextLast_s = (outIdx_r == IDX_W'(NSLICE-2));
            end
            MODE_SKIPZ: begin
                nextIdx_s  = heldHi_s[IDX_W-1:0];
                nextLast_s = ~heldLo_s[IDX_W];
            end
            default: begin
                nextIdx_s  = outIdx_r;
                nextLast_s = 1'b1;
            end
        endcase
    end

    // Input acceptance; the last-beat term keeps streaming bubble-free.
    always_comb begin
        if (rst) begin
            inReady_s = 1'b0;
        end else begin
            inReady_s = (state_r == ST_IDLE) |
                        ((state_r == ST_EMIT) & outLast_r & bus.out_ready);
        end
        acceptWord_s = bus.in_valid & inReady_s;
        advance_s    = (state_r == ST_EMIT) & bus.out_ready & ~outLast_r;
        finish_s     = (state_r == ST_EMIT) & bus.out_ready & outLast_r;
    end

    // State, held word and registered slice outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wordHeld_r <= {WORD_W{1'b0}};
            modeHeld_r <= 2'd0;
            maskHeld_r <= {NSLICE{1'b0}};
            outSlice_r <= {SLICE_W{1'b0}};
            outIdx_r   <= {IDX_W{1'b0}};
            outLast_r  <= 1'b0;
        end else if (acceptWord_s) begin
            state_r    <= ST_EMIT;
            wordHeld_r <= bus.in_word;
            modeHeld_r <= bus.in_mode;
            maskHeld_r <= inMask_s;
            outSlice_r <= sliceOf(bus.in_word, firstIdx_s);
            outIdx_r   <= firstIdx_s;
            outLast_r  <= firstLast_s;
        end else if (advance_s) begin
            outSlice_r <= sliceOf(wordHeld_r, nextIdx_s);
            outIdx_r   <= nextIdx_s;
            outLast_r  <= nextLast_s;
        end else if (finish_s) begin
            state_r    <= ST_IDLE;
        end else begin
            state_r    <= state_r;
        end
    end

    assign bus.in_ready  = inReady_s;
    assign bus.out_valid = (state_r == ST_EMIT);
    assign bus.out_slice = outSlice_r;
    assign bus.out_idx   = outIdx_r;
    assign bus.out_last  = outLast_r;

endmodule

// File: tb/tb_word_slice_serializer.sv
// Directed bench for word_slice_serializer: a 16/8 and a 32/8 instance,
// vector table for single words plus hand sequences for stall, streaming and reset.
module tb_word_slice_serializer;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        inValid;
    logic [31:0] inWord;
    logic [1:0]  inMode;
    logic        outReady;

    int checks;
    int errors;

    word_slice_serializer_if #(.WORD_W(16), .SLICE_W(8)) b16 ();
    word_slice_serializer_if #(.WORD_W(32), .SLICE_W(8)) b32 ();

    word_slice_serializer #(.WORD_W(16), .SLICE_W(8)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    word_slice_serializer #(.WORD_W(32), .SLICE_W(8)) dut32 (.clk(clk), .rst(rst), .bus(b32));

    assign b16.in_valid  = inValid & ~sel;
    assign b16.in_word   = inWord[15:0];
    assign b16.in_mode   = inMode;
    assign b16.out_ready = outReady;
    assign b32.in_valid  = inValid & sel;
    assign b32.in_word   = inWord;
    assign b32.in_mode   = inMode;
    assign b32.out_ready = outReady;

    logic [31:0] curValid, curInReady, curSlice, curIdx, curLast;
    assign curValid   = {31'd0, sel ? b32.out_valid : b16.out_valid};
    assign curInReady = {31'd0, sel ? b32.in_ready  : b16.in_ready};
    assign curSlice   = {24'd0, sel ? b32.out_slice : b16.out_slice};
    assign curIdx     = sel ? {30'd0, b32.out_idx} : {31'd0, b16.out_idx};
    assign curLast    = {31'd0, sel ? b32.out_last  : b16.out_last};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beats are packed first-beat-lowest: slices[8b+:8], idxs[2b+:2].
    typedef struct packed {
        logic        sel;
        logic [31:0] word;
        logic [1:0]  mode;
        logic [2:0]  n;
        logic [31:0] slices;
        logic [7:0]  idxs;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mkVec(input logic s, input logic [31:0] w, input logic [1:0] m,
                                   input logic [2:0] n, input logic [31:0] sl, input logic [7:0] ix);
        vec_t v;
        v.sel = s; v.word = w; v.mode = m; v.n = n; v.slices = sl; v.idxs = ix;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic runVec(input vec_t v, input int id);
        sel = v.sel;
        outReady = 1'b1;
        @(negedge clk);
        inValid = 1'b1; inWord = v.word; inMode = v.mode;
        #1 check($sformatf("v%0d_in_ready", id), curInReady, 32'd1);
        @(negedge clk);
        // Scramble inputs while emitting: only the accepted word/mode may matter.
        inValid = 1'b0; inWord = ~v.word; inMode = ~v.mode;
        for (int b = 0; b < int'(v.n); b++) begin
            check($sformatf("v%0d_valid%0d", id, b), curValid, 32'd1);
            check($sformatf("v%0d_slice%0d", id, b), curSlice, {24'd0, v.slices[b*8 +: 8]});
            check($sformatf("v%0d_idx%0d", id, b), curIdx, {30'd0, v.idxs[b*2 +: 2]});
            check($sformatf("v%0d_last%0d", id, b), curLast, (b == int'(v.n) - 1) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        check($sformatf("v%0d_idle", id), curValid, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; sel = 1'b0; inValid = 1'b0; inWord = 32'd0; inMode = 2'd0; outReady = 1'b1;

        vecs[0]  = mkVec(1'b0, 32'h0000A1B2, 2'd0, 3'd2, {8'h00, 8'h00, 8'hB2, 8'hA1}, {2'd0, 2'd0, 2'd0, 2'd1});
        vecs[1]  = mkVec(1'b0, 32'h0000A1B2, 2'd1, 3'd2, {8'h00, 8'h00, 8'hA1, 8'hB2}, {2'd0, 2'd0, 2'd1, 2'd0});
        vecs[2]  = mkVec(1'b0, 32'h00008100, 2'd2, 3'd1, 32'h00000000, 8'h00);
        vecs[3]  = mkVec(1'b0, 32'h00008000, 2'd2, 3'd1, 32'h00000080, 8'h01);
        vecs[4]  = mkVec(1'b0, 32'h00000100, 2'd2, 3'd1, 32'h00000001, 8'h01);
        vecs[5]  = mkVec(1'b0, 32'h00000000, 2'd3, 3'd1, 32'h00000000, 8'h00);
        vecs[6]  = mkVec(1'b0, 32'h000000FF, 2'd3, 3'd1, 32'h000000FF, 8'h00);
        vecs[7]  = mkVec(1'b0, 32'h00003400, 2'd3, 3'd1, 32'h00000034, 8'h01);
        vecs[8]  = mkVec(1'b1, 32'h00120034, 2'd3, 3'd2, {8'h00, 8'h00, 8'h34, 8'h12}, {2'd0, 2'd0, 2'd0, 2'd2});
        vecs[9]  = mkVec(1'b1, 32'h00000000, 2'd3, 3'd1, 32'h00000000, 8'h00);
        vecs[10] = mkVec(1'b1, 32'hFF000000, 2'd3, 3'd1, 32'h000000FF, 8'h03);
        vecs[11] = mkVec(1'b1, 32'h01020304, 2'd0, 3'd4, {8'h04, 8'h03, 8'h02, 8'h01}, {2'd0, 2'd1, 2'd2, 2'd3});
        vecs[12] = mkVec(1'b1, 32'h01020304, 2'd1, 3'd4, {8'h01, 8'h02, 8'h03, 8'h04}, {2'd3, 2'd2, 2'd1, 2'd0});
        vecs[13] = mkVec(1'b1, 32'h80000100, 2'd2, 3'd1, 32'h00000000, 8'h00);
        vecs[14] = mkVec(1'b1, 32'h12345678, 2'd2, 3'd1, 32'h00000012, 8'h03);
        vecs[15] = mkVec(1'b1, 32'hA0000B0C, 2'd3, 3'd3, {8'h00, 8'h0C, 8'h0B, 8'hA0}, {2'd0, 2'd0, 2'd1, 2'd3});

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready16", curInReady, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_valid16", curValid, 32'd0);
        check("rst_slice16", curSlice, 32'd0);
        check("rst_idx16", curIdx, 32'd0);
        check("rst_last16", curLast, 32'd0);
        check("idle_in_ready16", curInReady, 32'd1);
        sel = 1'b1;
        #1;
        check("rst_valid32", curValid, 32'd0);
        check("rst_slice32", curSlice, 32'd0);

        for (int i = 0; i < 16; i++) begin
            runVec(vecs[i], i);
        end

        // LSB-first with a 3-cycle stall after the first beat.
        sel = 1'b0;
        @(negedge clk);
        inValid = 1'b1; inWord = 32'h0000A1B2; inMode = 2'd1;
        @(negedge clk);
        inValid = 1'b0; outReady = 1'b0;
        for (int s = 0; s < 4; s++) begin
            check($sformatf("stall_valid%0d", s), curValid, 32'd1);
            check($sformatf("stall_slice%0d", s), curSlice, 32'h000000B2);
            check($sformatf("stall_idx%0d", s), curIdx, 32'd0);
            check($sformatf("stall_last%0d", s), curLast, 32'd0);
            check($sformatf("stall_in_ready%0d", s), curInReady, 32'd0);
            if (s == 3) outReady = 1'b1;
            @(negedge clk);
        end
        check("stall_slice_b1", curSlice, 32'h000000A1);
        check("stall_idx_b1", curIdx, 32'd1);
        check("stall_last_b1", curLast, 32'd1);
        check("stall_in_ready_last", curInReady, 32'd1);
        @(negedge clk);
        check("stall_idle", curValid, 32'd0);

        // Back-to-back words with no bubble.
        @(negedge clk);
        inValid = 1'b1; inWord = 32'h00001122; inMode = 2'd0;
        @(negedge clk);
        check("b2b_slice0", curSlice, 32'h00000011);
        check("b2b_in_ready0", curInReady, 32'd0);
        inWord = 32'h00003344;
        @(negedge clk);
        check("b2b_slice1", curSlice, 32'h00000022);
        check("b2b_last1", curLast, 32'd1);
        check("b2b_in_ready1", curInReady, 32'd1);
        @(negedge clk);
        inValid = 1'b0;
        check("b2b_valid2", curValid, 32'd1);
        check("b2b_slice2", curSlice, 32'h00000033);
        check("b2b_idx2", curIdx, 32'd1);
        check("b2b_last2", curLast, 32'd0);
        @(negedge clk);
        check("b2b_valid3", curValid, 32'd1);
        check("b2b_slice3", curSlice, 32'h00000044);
        check("b2b_last3", curLast, 32'd1);
        @(negedge clk);
        check("b2b_idle", curValid, 32'd0);

        // Reset in the middle of a word.
        @(negedge clk);
        inValid = 1'b1; inWord = 32'h00001122; inMode = 2'd0;
        @(negedge clk);
        inValid = 1'b0;
        check("mid_slice0", curSlice, 32'h00000011);
        rst = 1'b1;
        #1 check("mid_rst_in_ready", curInReady, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", curValid, 32'd0);
        check("mid_rst_slice", curSlice, 32'd0);
        check("mid_rst_idx", curIdx, 32'd0);
        check("mid_rst_last", curLast, 32'd0);
        runVec(mkVec(1'b0, 32'h00005566, 2'd0, 3'd2, {8'h00, 8'h00, 8'h66, 8'h55}, {2'd0, 2'd0, 2'd0, 2'd1}), 99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
